// File: rtl/softmax_max_sub.sv
// rtl/softmax_max_sub.sv - row-buffered max subtraction feeding the PWL exp approximator
module softmax_max_sub #(
   parameter int M       = 4,
   parameter int N       = 8,
   parameter int ROW_LEN = 16,
   parameter int PWL_LAT = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [M+N-1:0]   i_in_data,
   input  logic             i_in_last,
   output logic             o_out_valid,
   output logic [M+N-1:0]   o_out_data,
   output logic             o_out_last,
   output logic             o_pwl_valid,
   output logic             o_pwl_last,
   output logic [M+N-1:0]   o_row_max,
   output logic             o_len_err
);

   localparam int W  = M + N;
   localparam int PW = $clog2(ROW_LEN);
   localparam logic [PW-1:0] LAST_SLOT = PW'(ROW_LEN - 1);

   typedef enum logic {S_LOAD, S_DRAIN} state_t;

   state_t              r_state;
   logic [PW-1:0]       r_wr_ptr;
   logic [PW-1:0]       r_rd_ptr;
   logic [PW-1:0]       r_last_idx;   // index of the final element, i.e. len-1
   logic [W-1:0]        r_buf [ROW_LEN];
   logic [W-1:0]        r_row_max;
   logic [W-1:0]        r_out_data;
   logic                r_out_valid;
   logic                r_out_last;
   logic                r_len_err;
   logic [PWL_LAT-1:0]  r_pwl_valid_sr;
   logic [PWL_LAT-1:0]  r_pwl_last_sr;

   logic                w_xfer;
   logic [W-1:0]        w_rd_elem;
   logic [W:0]          w_diff;
   logic [W-1:0]        w_sat;

   assign w_xfer    = i_in_valid && (r_state == S_LOAD);
   assign w_rd_elem = r_buf[r_rd_ptr];

   // x - max in W+1 bits; it is never positive, so the only overflow is below -2^(W-1)
   always_comb begin
      w_diff = {w_rd_elem[W-1], w_rd_elem} - {r_row_max[W-1], r_row_max};
      w_sat  = w_diff[W-1:0];
      if (w_diff[W] != w_diff[W-1]) begin
         w_sat = {1'b1, {(W-1){1'b0}}};
      end
   end

   // Row storage; contents need no reset since the pointers gate every read
   always_ff @(posedge i_clk) begin
      if (w_xfer) begin
         r_buf[r_wr_ptr] <= i_in_data;
      end
   end

   // LOAD/DRAIN control with row max tracking and registered stream outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_LOAD;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_last_idx  <= '0;
         r_row_max   <= '0;
         r_len_err   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
         case (r_state)
            S_LOAD: begin
               if (w_xfer) begin
                  // first element of a row replaces the previous row's max outright
                  if ((r_wr_ptr == '0) || ($signed(i_in_data) > $signed(r_row_max))) begin
                     r_row_max <= i_in_data;
                  end
                  if (i_in_last || (r_wr_ptr == LAST_SLOT)) begin
                     r_state    <= S_DRAIN;
                     r_last_idx <= r_wr_ptr;
                     r_wr_ptr   <= '0;
                     r_rd_ptr   <= '0;
                     if (!i_in_last) begin
                        r_len_err <= 1'b1;
                     end
                  end else begin
                     r_wr_ptr <= r_wr_ptr + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_sat;
               r_out_last  <= (r_rd_ptr == r_last_idx);
               if (r_rd_ptr == r_last_idx) begin
                  r_state  <= S_LOAD;
                  r_rd_ptr <= '0;
               end else begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
               end
            end
            default: begin
               r_state <= S_LOAD;
            end
         endcase
      end
   end

   // Shadow of the PWL pipeline so downstream can qualify y_out
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pwl_valid_sr <= '0;
         r_pwl_last_sr  <= '0;
      end else begin
         for (int i = PWL_LAT - 1; i > 0; i--) begin
            r_pwl_valid_sr[i] <= r_pwl_valid_sr[i-1];
            r_pwl_last_sr[i]  <= r_pwl_last_sr[i-1];
         end
         r_pwl_valid_sr[0] <= r_out_valid;
         r_pwl_last_sr[0]  <= r_out_last;
      end
   end

   assign o_in_ready  = (r_state == S_LOAD);
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_last  = r_out_last;
   assign o_pwl_valid = r_pwl_valid_sr[PWL_LAT-1];
   assign o_pwl_last  = r_pwl_last_sr[PWL_LAT-1];
   assign o_row_max   = r_row_max;
   assign o_len_err   = r_len_err;

endmodule

// File: tb/tb_softmax_max_sub.sv
// tb/tb_softmax_max_sub.sv - directed self-checking bench for softmax_max_sub
module tb_softmax_max_sub;

   localparam int W       = 12;
   localparam int ROW_LEN = 16;
   localparam int PWL_LAT = 5;
   localparam int MONSZ   = 4096;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_in_valid = 1'b0;
   logic [W-1:0]  i_in_data = '0;
   logic          i_in_last = 1'b0;
   logic          o_in_ready;
   logic          o_out_valid;
   logic [W-1:0]  o_out_data;
   logic          o_out_last;
   logic          o_pwl_valid;
   logic          o_pwl_last;
   logic [W-1:0]  o_row_max;
   logic          o_len_err;

   softmax_max_sub #(.M(4), .N(8), .ROW_LEN(ROW_LEN), .PWL_LAT(PWL_LAT)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_data   (i_in_data),
      .i_in_last   (i_in_last),
      .o_out_valid (o_out_valid),
      .o_out_data  (o_out_data),
      .o_out_last  (o_out_last),
      .o_pwl_valid (o_pwl_valid),
      .o_pwl_last  (o_pwl_last),
      .o_row_max   (o_row_max),
      .o_len_err   (o_len_err)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic          mon_v  [MONSZ];
   logic [W-1:0]  mon_d  [MONSZ];
   logic          mon_l  [MONSZ];
   logic          mon_pv [MONSZ];
   logic          mon_pl [MONSZ];
   logic          mon_r  [MONSZ];

   logic [W-1:0]  row_d [ROW_LEN];
   logic [W-1:0]  row_e [ROW_LEN];
   logic [W-1:0]  exp_max;

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (cyc < MONSZ) begin
         mon_v[cyc]  = o_out_valid;
         mon_d[cyc]  = o_out_data;
         mon_l[cyc]  = o_out_last;
         mon_pv[cyc] = o_pwl_valid;
         mon_pl[cyc] = o_pwl_last;
         mon_r[cyc]  = o_in_ready;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic send(input logic [W-1:0] d, input logic l);
      i_in_valid = 1'b1;
      i_in_data  = d;
      i_in_last  = l;
      @(posedge i_clk);
      #1;
      i_in_valid = 1'b0;
      i_in_data  = '0;
      i_in_last  = 1'b0;
   endtask

   task automatic do_row(input int n, input int gap, input bit use_last, input string tag);
      int t;
      for (int i = 0; i < n; i++) begin
         send(row_d[i], use_last && (i == n - 1));
         if (i != n - 1) idle(gap);
      end
      t = cyc - 1;
      idle(n + 10);
      chk($sformatf("%s.rdy_T", tag), 32'(mon_r[t]), 32'd1);
      chk($sformatf("%s.pre_v", tag), 32'(mon_v[t+1]), 32'd0);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s.v[%0d]", tag, i), 32'(mon_v[t+2+i]), 32'd1);
         chk($sformatf("%s.d[%0d]", tag, i), 32'(mon_d[t+2+i]), 32'(row_e[i]));
         chk($sformatf("%s.l[%0d]", tag, i), 32'(mon_l[t+2+i]), 32'(i == n - 1));
         chk($sformatf("%s.pv[%0d]", tag, i), 32'(mon_pv[t+2+i+PWL_LAT]), 32'd1);
         chk($sformatf("%s.pl[%0d]", tag, i), 32'(mon_pl[t+2+i+PWL_LAT]), 32'(i == n - 1));
         chk($sformatf("%s.rdy_lo[%0d]", tag, i), 32'(mon_r[t+1+i]), 32'd0);
      end
      chk($sformatf("%s.post_v", tag), 32'(mon_v[t+2+n]), 32'd0);
      chk($sformatf("%s.pre_pv", tag), 32'(mon_pv[t+1+PWL_LAT]), 32'd0);
      chk($sformatf("%s.post_pv", tag), 32'(mon_pv[t+2+n+PWL_LAT]), 32'd0);
      chk($sformatf("%s.rdy_back", tag), 32'(mon_r[t+1+n]), 32'd1);
      chk($sformatf("%s.rmax", tag), 32'(o_row_max), 32'(exp_max));
   endtask

   initial begin
      int t;
      int hits;

      // reset state
      idle(3);
      chk("rst.rdy", 32'(o_in_ready), 32'd1);
      chk("rst.v", 32'(o_out_valid), 32'd0);
      chk("rst.d", 32'(o_out_data), 32'd0);
      chk("rst.l", 32'(o_out_last), 32'd0);
      chk("rst.pv", 32'(o_pwl_valid), 32'd0);
      chk("rst.pl", 32'(o_pwl_last), 32'd0);
      chk("rst.rmax", 32'(o_row_max), 32'd0);
      chk("rst.lerr", 32'(o_len_err), 32'd0);
      i_rst = 1'b0;
      idle(2);

      // {1.0, 3.0, 2.0}
      row_d[0] = 12'h100; row_e[0] = 12'hE00;
      row_d[1] = 12'h300; row_e[1] = 12'h000;
      row_d[2] = 12'h200; row_e[2] = 12'hF00;
      exp_max = 12'h300;
      do_row(3, 0, 1'b1, "r3");
      chk("r3.lerr", 32'(o_len_err), 32'd0);

      // saturation: 0x800 - 0x7FF = -4095 clamps to 0x800
      row_d[0] = 12'h7FF; row_e[0] = 12'h000;
      row_d[1] = 12'h800; row_e[1] = 12'h800;
      exp_max = 12'h7FF;
      do_row(2, 0, 1'b1, "sat");

      // single element below the previous max: max must be reloaded, not kept
      row_d[0] = 12'hA00; row_e[0] = 12'h000;
      exp_max = 12'hA00;
      do_row(1, 0, 1'b1, "one");
      chk("one.lerr", 32'(o_len_err), 32'd0);

      // full row without last: forced end, sticky length error
      for (int i = 0; i < ROW_LEN; i++) begin
         row_d[i] = 12'(i * 16);
         row_e[i] = 12'(12'hF10 + i * 16);
      end
      exp_max = 12'h0F0;
      do_row(ROW_LEN, 0, 1'b0, "full");
      chk("full.lerr", 32'(o_len_err), 32'd1);

      // sparse input, one valid every third cycle
      row_d[0] = 12'h080; row_e[0] = 12'hF80;
      row_d[1] = 12'hFFF; row_e[1] = 12'hEFF;
      row_d[2] = 12'h100; row_e[2] = 12'h000;
      row_d[3] = 12'h0C0; row_e[3] = 12'hFC0;
      exp_max = 12'h100;
      do_row(4, 2, 1'b1, "gap");
      chk("gap.lerr_sticky", 32'(o_len_err), 32'd1);

      // reset on the second DRAIN cycle of a 6-element row
      send(12'h100, 1'b0);
      send(12'h200, 1'b0);
      send(12'h500, 1'b0);
      send(12'h300, 1'b0);
      send(12'h400, 1'b0);
      send(12'h000, 1'b1);
      t = cyc - 1;
      idle(1);
      i_rst = 1'b1;
      idle(1);
      chk("mrst.rdy", 32'(o_in_ready), 32'd1);
      chk("mrst.v", 32'(o_out_valid), 32'd0);
      chk("mrst.d", 32'(o_out_data), 32'd0);
      chk("mrst.l", 32'(o_out_last), 32'd0);
      chk("mrst.pv", 32'(o_pwl_valid), 32'd0);
      chk("mrst.rmax", 32'(o_row_max), 32'd0);
      chk("mrst.lerr", 32'(o_len_err), 32'd0);
      i_rst = 1'b0;
      idle(14);
      hits = 0;
      for (int c = t + 3; c <= t + 15; c++) begin
         if (mon_v[c] || mon_pv[c]) hits++;
      end
      chk("mrst.no_partial", 32'(hits), 32'd0);

      // row after the reset, all negative
      row_d[0] = 12'hF00; row_e[0] = 12'h000;
      row_d[1] = 12'hE00; row_e[1] = 12'hF00;
      exp_max = 12'hF00;
      do_row(2, 0, 1'b1, "post");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
